// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle of the signals exchanged between the pipeline sequencing controller
// and the IF/ID/EX datapath. Signal suffixes are written from the
// controller's point of view (_i = into the controller, _o = out of it).
//
//   master : the controller (pipe_ctrl). Takes decode/EX/bus status and
//            drives the hold, flush, redirect, error and stall-count outputs.
//   slave  : the datapath side. Drives the status, consumes the controls.
//
// Status from decode : id_reg{1,2}_raddr_i, id_reg{1,2}_re_i
// Status from EX     : ex_reg_waddr_i, ex_reg_we_i, ex_is_load_i,
//                      ex_jump_flag_i, ex_jump_addr_i
// Status from bus    : bus_hold_i, muldiv_busy_i
// Controls           : hold_pc_o, hold_if_id_o, hold_id_ex_o,
//                      flush_if_id_o, flush_id_ex_o,
//                      jump_flag_o, jump_addr_o, bus_err_o
// Statistics         : stall_cnt_o
//
// There is no valid/ready handshake here. Every control is a level that is
// valid for the current cycle only and is acted on at the next rising clock
// edge; the datapath must not register or stretch it.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;
   logic [4:0]  id_reg1_raddr_i;
   logic [4:0]  id_reg2_raddr_i;
   logic        id_reg1_re_i;
   logic        id_reg2_re_i;
   logic [4:0]  ex_reg_waddr_i;
   logic        ex_reg_we_i;
   logic        ex_is_load_i;
   logic        ex_jump_flag_i;
   logic [31:0] ex_jump_addr_i;
   logic        bus_hold_i;
   logic        muldiv_busy_i;

   logic        hold_pc_o;
   logic        hold_if_id_o;
   logic        hold_id_ex_o;
   logic        flush_if_id_o;
   logic        flush_id_ex_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        bus_err_o;
   logic [31:0] stall_cnt_o;

   modport master (
      input  id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_re_i, id_reg2_re_i,
      input  ex_reg_waddr_i, ex_reg_we_i, ex_is_load_i,
      input  ex_jump_flag_i, ex_jump_addr_i, bus_hold_i, muldiv_busy_i,
      output hold_pc_o, hold_if_id_o, hold_id_ex_o,
      output flush_if_id_o, flush_id_ex_o,
      output jump_flag_o, jump_addr_o, bus_err_o, stall_cnt_o
   );

   modport slave (
      output id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_re_i, id_reg2_re_i,
      output ex_reg_waddr_i, ex_reg_we_i, ex_is_load_i,
      output ex_jump_flag_i, ex_jump_addr_i, bus_hold_i, muldiv_busy_i,
      input  hold_pc_o, hold_if_id_o, hold_id_ex_o,
      input  flush_if_id_o, flush_id_ex_o,
      input  jump_flag_o, jump_addr_o, bus_err_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the IF/ID/EX core. It does four things:
//   - redirects the PC on a taken jump and flushes IF/ID and ID/EX,
//   - freezes the pipe while the bus or the mul/div unit is busy, and traps
//     to TRAP_ADDR if that wait goes on longer than HOLD_TIMEOUT cycles,
//   - inserts a single bubble on a load-use hazard,
//   - counts the cycles in which the PC is frozen (saturating).
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active low
//   pif          : pipe_ctrl_if.master (status in, controls out)
//   dbg_state_o  : current FSM state (0 RUN, 1 BUBBLE, 2 HOLD, 3 ERR)
//
// Parameters
//   HOLD_TIMEOUT : consecutive hold cycles before the wait is aborted (>=2)
//   TRAP_ADDR    : PC target issued on a hold timeout
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int unsigned HOLD_TIMEOUT = 16,
   parameter logic [31:0] TRAP_ADDR    = 32'h0000_0004
) (
   input  logic               clk,
   input  logic               rst,
   pipe_ctrl_if.master        pif,
   output logic [1:0]         dbg_state_o
);

   localparam int unsigned       CNT_W     = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(HOLD_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [31:0]      stall_cnt_q;

   logic        hold_req;
   logic        load_use;
   logic        rs1_hit;
   logic        rs2_hit;

   // Ungated controls; they are forced to zero below while reset is low.
   logic        hold_pc;
   logic        hold_if_id;
   logic        hold_id_ex;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        bus_err;

   assign hold_req = pif.bus_hold_i | pif.muldiv_busy_i;

   assign rs1_hit  = pif.id_reg1_re_i && (pif.id_reg1_raddr_i == pif.ex_reg_waddr_i);
   assign rs2_hit  = pif.id_reg2_re_i && (pif.id_reg2_raddr_i == pif.ex_reg_waddr_i);
   // x0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign load_use = pif.ex_is_load_i && pif.ex_reg_we_i &&
                     (pif.ex_reg_waddr_i != 5'd0) && (rs1_hit || rs2_hit);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         hold_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         if (hold_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_RUN, ST_BUBBLE: begin
            if (pif.ex_jump_flag_i) begin
               state_d = ST_RUN;
            end else if (hold_req) begin
               // The entry cycle already holds, so it counts as hold cycle 1.
               state_d    = ST_HOLD;
               hold_cnt_d = CNT_ONE;
            end else if (load_use && (state_q == ST_RUN)) begin
               // The instruction behind the load is still the same one in
               // BUBBLE, so the hazard is ignored there: one bubble only.
               state_d = ST_BUBBLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (!hold_req) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else if (hold_cnt_q < TIMEOUT_C) begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
            end else begin
               state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
         end
         default: begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
         end
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_flag   = 1'b0;
      jump_addr   = 32'd0;
      bus_err     = 1'b0;
      if (rst) begin
         case (state_q)
            ST_RUN, ST_BUBBLE: begin
               if (pif.ex_jump_flag_i) begin
                  jump_flag   = 1'b1;
                  jump_addr   = pif.ex_jump_addr_i;
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (hold_req) begin
                  hold_pc    = 1'b1;
                  hold_if_id = 1'b1;
                  hold_id_ex = 1'b1;
               end else if (load_use && (state_q == ST_RUN)) begin
                  // Freeze the front end and push a NOP into EX.
                  hold_pc     = 1'b1;
                  hold_if_id  = 1'b1;
                  flush_id_ex = 1'b1;
               end
            end
            ST_HOLD: begin
               // EX is frozen here, so a jump flag cannot be new and is
               // left for RUN to act on after release.
               if (hold_req && (hold_cnt_q < TIMEOUT_C)) begin
                  hold_pc    = 1'b1;
                  hold_if_id = 1'b1;
                  hold_id_ex = 1'b1;
               end
            end
            ST_ERR: begin
               bus_err     = 1'b1;
               jump_flag   = 1'b1;
               jump_addr   = TRAP_ADDR;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end
            default: begin
               hold_pc = 1'b0;
            end
         endcase
      end
   end

   assign pif.hold_pc_o     = hold_pc;
   assign pif.hold_if_id_o  = hold_if_id;
   assign pif.hold_id_ex_o  = hold_id_ex;
   assign pif.flush_if_id_o = flush_if_id;
   assign pif.flush_id_ex_o = flush_id_ex;
   assign pif.jump_flag_o   = jump_flag;
   assign pif.jump_addr_o   = jump_addr;
   assign pif.bus_err_o     = bus_err;
   assign pif.stall_cnt_o   = stall_cnt_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Each cycle's expected
// control vector {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex,
// jump_flag, bus_err, jump_addr} is pushed to exp_q when the stimulus is
// applied and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int          W         = 39;
   localparam int unsigned TIMEOUT   = 16;
   localparam logic [1:0]  S_RUN     = 2'd0;
   localparam logic [1:0]  S_BUBBLE  = 2'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  dbg_state;

   pipe_ctrl_if pif();

   pipe_ctrl #(
      .HOLD_TIMEOUT (TIMEOUT),
      .TRAP_ADDR    (32'h0000_0004)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pif         (pif),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got;
   logic [W-1:0] exp;
   logic [31:0]  stall_exp;
   int           chk_cnt  = 0;
   int           pass_cnt = 0;

   function automatic logic [W-1:0] ctl(bit hpc, bit hif, bit hidex, bit fif,
                                       bit fidex, bit jf, bit berr,
                                       logic [31:0] addr);
      return {hpc, hif, hidex, fif, fidex, jf, berr, addr};
   endfunction

   function automatic logic [W-1:0] dut_ctl();
      return {pif.hold_pc_o, pif.hold_if_id_o, pif.hold_id_ex_o,
              pif.flush_if_id_o, pif.flush_id_ex_o, pif.jump_flag_o,
              pif.bus_err_o, pif.jump_addr_o};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      pif.id_reg1_raddr_i = 5'd0;
      pif.id_reg2_raddr_i = 5'd0;
      pif.id_reg1_re_i    = 1'b0;
      pif.id_reg2_re_i    = 1'b0;
      pif.ex_reg_waddr_i  = 5'd0;
      pif.ex_reg_we_i     = 1'b0;
      pif.ex_is_load_i    = 1'b0;
      pif.ex_jump_flag_i  = 1'b0;
      pif.ex_jump_addr_i  = 32'd0;
      pif.bus_hold_i      = 1'b0;
      pif.muldiv_busy_i   = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] waddr);
      pif.ex_is_load_i   = 1'b1;
      pif.ex_reg_we_i    = 1'b1;
      pif.ex_reg_waddr_i = waddr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      set_idle();
      pif.bus_hold_i     = 1'b1;
      pif.ex_jump_flag_i = 1'b1;
      pif.ex_jump_addr_i = 32'hDEAD_BEEF;
      exp_q.push_back('0);
      @(negedge clk);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL reset_ctl: got %h expected %h", got, exp);
      else pass_cnt++;
      chk_cnt++;
      if (pif.stall_cnt_o !== 32'd0) $display("FAIL reset_stall: got %0d expected 0", pif.stall_cnt_o);
      else pass_cnt++;
      chk_cnt++;
      if (dbg_state !== S_RUN) $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_RUN);
      else pass_cnt++;
      set_idle();
      @(posedge clk);
      #1 rst = 1'b1;
      stall_exp = 32'd0;
      exp_q.push_back('0);
      @(negedge clk);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL reset_release: got %h expected %h", got, exp);
      else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_load_use();
      for (int it = 0; it < 4; it++) begin
         logic [4:0] r;
         r = 5'($urandom_range(1, 31));
         set_idle();
         set_load(r);
         if ((it % 2) == 1) begin
            pif.id_reg2_raddr_i = r;
            pif.id_reg2_re_i    = 1'b1;
            pif.id_reg1_raddr_i = r ^ 5'd1;
            pif.id_reg1_re_i    = 1'($urandom_range(0, 1));
         end else begin
            pif.id_reg1_raddr_i = r;
            pif.id_reg1_re_i    = 1'b1;
         end
         exp_q.push_back(ctl(1, 1, 0, 0, 1, 0, 0, 32'd0));
         stall_exp = stall_exp + 32'd1;
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL load_use_bubble it%0d: got %h expected %h", it, got, exp);
         else pass_cnt++;
         next_cycle();
         // Same inputs one cycle later: the single bubble has been inserted.
         exp_q.push_back('0);
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL load_use_second it%0d: got %h expected %h", it, got, exp);
         else pass_cnt++;
         chk_cnt++;
         if (dbg_state !== S_BUBBLE) $display("FAIL load_use_state it%0d: got %0d expected %0d", it, dbg_state, S_BUBBLE);
         else pass_cnt++;
         next_cycle();
         set_idle();
         exp_q.push_back('0);
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL load_use_idle it%0d: got %h expected %h", it, got, exp);
         else pass_cnt++;
         chk_cnt++;
         if (pif.stall_cnt_o !== stall_exp) $display("FAIL load_use_stall it%0d: got %0d expected %0d", it, pif.stall_cnt_o, stall_exp);
         else pass_cnt++;
         next_cycle();
      end
   endtask

   task automatic test_no_stall();
      for (int c = 0; c < 4; c++) begin
         set_idle();
         case (c)
            0: begin
               set_load(5'd0);
               pif.id_reg1_raddr_i = 5'd0; pif.id_reg1_re_i = 1'b1;
            end
            1: begin
               set_load(5'd7);
               pif.id_reg2_raddr_i = 5'd7; pif.id_reg2_re_i = 1'b0;
               pif.id_reg1_raddr_i = 5'd3; pif.id_reg1_re_i = 1'b1;
            end
            2: begin
               set_load(5'd9);
               pif.ex_is_load_i    = 1'b0;
               pif.id_reg1_raddr_i = 5'd9; pif.id_reg1_re_i = 1'b1;
            end
            default: begin
               set_load(5'd9);
               pif.ex_reg_we_i     = 1'b0;
               pif.id_reg1_raddr_i = 5'd9; pif.id_reg1_re_i = 1'b1;
            end
         endcase
         exp_q.push_back('0);
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL no_stall case%0d: got %h expected %h", c, got, exp);
         else pass_cnt++;
         next_cycle();
      end
      set_idle();
      @(negedge clk);
      chk_cnt++;
      if (pif.stall_cnt_o !== stall_exp) $display("FAIL no_stall_count: got %0d expected %0d", pif.stall_cnt_o, stall_exp);
      else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_jump_priority();
      logic [31:0] tgt;
      set_idle();
      set_load(5'd5);
      pif.id_reg1_raddr_i = 5'd5; pif.id_reg1_re_i = 1'b1;
      pif.bus_hold_i      = 1'b1;
      pif.ex_jump_flag_i  = 1'b1;
      pif.ex_jump_addr_i  = 32'h123;
      exp_q.push_back(ctl(0, 0, 0, 1, 1, 1, 0, 32'h123));
      @(negedge clk);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL jump_priority: got %h expected %h", got, exp);
      else pass_cnt++;
      next_cycle();
      set_idle();
      exp_q.push_back('0);
      @(negedge clk);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL jump_after: got %h expected %h", got, exp);
      else pass_cnt++;
      chk_cnt++;
      if (dbg_state !== S_RUN) $display("FAIL jump_state: got %0d expected %0d", dbg_state, S_RUN);
      else pass_cnt++;
      next_cycle();
      // A jump arriving while a bubble is being inserted still wins.
      set_load(5'd12);
      pif.id_reg2_raddr_i = 5'd12; pif.id_reg2_re_i = 1'b1;
      exp_q.push_back(ctl(1, 1, 0, 0, 1, 0, 0, 32'd0));
      stall_exp = stall_exp + 32'd1;
      @(negedge clk);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL jump_bubble_setup: got %h expected %h", got, exp);
      else pass_cnt++;
      next_cycle();
      tgt = $urandom & 32'hFFFF_FFFC;
      pif.ex_jump_flag_i = 1'b1;
      pif.ex_jump_addr_i = tgt;
      exp_q.push_back(ctl(0, 0, 0, 1, 1, 1, 0, tgt));
      @(negedge clk);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL jump_in_bubble: got %h expected %h", got, exp);
      else pass_cnt++;
      next_cycle();
      set_idle();
      next_cycle();
   endtask

   task automatic test_bus_hold();
      logic [31:0] tgt;
      for (int i = 1; i <= 4; i++) begin
         set_idle();
         pif.bus_hold_i = (i <= 3);
         if (i <= 3) begin
            exp_q.push_back(ctl(1, 1, 1, 0, 0, 0, 0, 32'd0));
            stall_exp = stall_exp + 32'd1;
         end else begin
            exp_q.push_back('0);
         end
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL bus_hold c%0d: got %h expected %h", i, got, exp);
         else pass_cnt++;
         next_cycle();
      end
      @(negedge clk);
      chk_cnt++;
      if (pif.stall_cnt_o !== stall_exp) $display("FAIL bus_hold_stall: got %0d expected %0d", pif.stall_cnt_o, stall_exp);
      else pass_cnt++;
      chk_cnt++;
      if (dbg_state !== S_RUN) $display("FAIL bus_hold_state: got %0d expected %0d", dbg_state, S_RUN);
      else pass_cnt++;
      next_cycle();
      // mul/div busy, with a jump flag raised while frozen: taken after release.
      tgt = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
      for (int i = 1; i <= 5; i++) begin
         set_idle();
         pif.muldiv_busy_i  = (i <= 2);
         pif.ex_jump_flag_i = (i >= 2) && (i <= 4);
         pif.ex_jump_addr_i = tgt;
         case (i)
            1, 2: begin
               exp_q.push_back(ctl(1, 1, 1, 0, 0, 0, 0, 32'd0));
               stall_exp = stall_exp + 32'd1;
            end
            4: exp_q.push_back(ctl(0, 0, 0, 1, 1, 1, 0, tgt));
            default: exp_q.push_back('0);
         endcase
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL muldiv_hold c%0d: got %h expected %h", i, got, exp);
         else pass_cnt++;
         next_cycle();
      end
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= 19; i++) begin
         set_idle();
         pif.bus_hold_i = (i <= 18);
         if (i <= TIMEOUT) begin
            exp_q.push_back(ctl(1, 1, 1, 0, 0, 0, 0, 32'd0));
            stall_exp = stall_exp + 32'd1;
         end else if (i == 18) begin
            exp_q.push_back(ctl(0, 0, 0, 1, 1, 1, 1, 32'h4));
         end else begin
            exp_q.push_back('0);
         end
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL timeout c%0d: got %h expected %h", i, got, exp);
         else pass_cnt++;
         next_cycle();
      end
      @(negedge clk);
      chk_cnt++;
      if (pif.stall_cnt_o !== stall_exp) $display("FAIL timeout_stall: got %0d expected %0d", pif.stall_cnt_o, stall_exp);
      else pass_cnt++;
      chk_cnt++;
      if (dbg_state !== S_RUN) $display("FAIL timeout_state: got %0d expected %0d", dbg_state, S_RUN);
      else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 5; i++) begin
         set_idle();
         pif.bus_hold_i = 1'b1;
         exp_q.push_back(ctl(1, 1, 1, 0, 0, 0, 0, 32'd0));
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL areset_hold c%0d: got %h expected %h", i, got, exp);
         else pass_cnt++;
         if (i < 5) next_cycle();
      end
      // Mid-cycle, away from any clock edge.
      #2 rst = 1'b0;
      stall_exp = 32'd0;
      #1;
      exp_q.push_back('0);
      got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
      if (got !== exp) $display("FAIL areset_ctl: got %h expected %h", got, exp);
      else pass_cnt++;
      chk_cnt++;
      if (pif.stall_cnt_o !== 32'd0) $display("FAIL areset_stall: got %0d expected 0", pif.stall_cnt_o);
      else pass_cnt++;
      chk_cnt++;
      if (dbg_state !== S_RUN) $display("FAIL areset_state: got %0d expected %0d", dbg_state, S_RUN);
      else pass_cnt++;
      next_cycle();
      set_idle();
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back('0);
         @(negedge clk);
         got = dut_ctl(); exp = exp_q.pop_front(); chk_cnt++;
         if (got !== exp) $display("FAIL areset_after c%0d: got %h expected %h", i, got, exp);
         else pass_cnt++;
         next_cycle();
      end
      @(negedge clk);
      chk_cnt++;
      if ((pif.stall_cnt_o !== stall_exp) || (dbg_state !== S_RUN))
         $display("FAIL areset_final: got stall %0d state %0d expected stall %0d state %0d",
                  pif.stall_cnt_o, dbg_state, stall_exp, S_RUN);
      else pass_cnt++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      stall_exp = 32'd0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_jump_priority();
      test_bus_hold();
      test_timeout();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID/EX core.
- Takes register read addresses and enables from the decode stage, plus destination, load, jump and busy status from EX and the bus.
- Produces PC hold, stage hold and flush controls and the redirected PC target.
- Adds load-use bubble insertion, bounded bus-wait holding with timeout trap, and a stall-cycle counter.

Parameters:
HOLD_TIMEOUT, 16, consecutive hold cycles after which the wait is aborted (≥2)
TRAP_ADDR, 32'h00000004, PC target issued on hold timeout

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
id_reg1_raddr_i  input  5  rs1 address from decode
id_reg2_raddr_i  input  5  rs2 address from decode
id_reg1_re_i  input  1  decode instruction reads rs1
id_reg2_re_i  input  1  decode instruction reads rs2
ex_reg_waddr_i  input  5  destination register of EX-stage instruction
ex_reg_we_i  input  1  EX instruction writes a register
ex_is_load_i  input  1  EX instruction is a load
ex_jump_flag_i  input  1  EX resolved a taken jump/branch
ex_jump_addr_i  input  32  jump target
bus_hold_i  input  1  memory bus not ready
muldiv_busy_i  input  1  multi-cycle mul/div in progress
hold_pc_o  output  1  freeze PC
hold_if_id_o  output  1  freeze IF/ID register
hold_id_ex_o  output  1  freeze ID/EX register
flush_if_id_o  output  1  load NOP into IF/ID
flush_id_ex_o  output  1  load NOP into ID/EX
jump_flag_o  output  1  PC takes jump_addr_o next edge
jump_addr_o  output  32  redirect target
bus_err_o  output  1  one-cycle pulse on hold timeout
stall_cnt_o  output  32  saturating count of cycles with hold_pc_o=1

Behaviour:
- State register: RUN, BUBBLE, HOLD, ERR. Reset (rst=0, async) → RUN, hold_cnt=0, stall_cnt_o=0.
- All control outputs are combinational from state and inputs. Every control output is forced to 0 while rst=0, and jump_addr_o=0.
- Default every cycle: all outputs 0, jump_addr_o=0.
- hold_req = bus_hold_i | muldiv_busy_i.
- load_use = ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i≠0) & ((id_reg1_re_i & id_reg1_raddr_i==ex_reg_waddr_i) | (id_reg2_re_i & id_reg2_raddr_i==ex_reg_waddr_i)).
- RUN/BUBBLE decisions, in priority order:
  1. ex_jump_flag_i → jump_flag_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; next state RUN. A jump beats a simultaneous hold_req or load_use.
  2. hold_req → hold_pc_o=hold_if_id_o=hold_id_ex_o=1; hold_cnt←1; next state HOLD.
  3. load_use, only in RUN → hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1; next state BUBBLE. Exactly one bubble is inserted.
  4. Otherwise next state RUN.
  - In BUBBLE, load_use is ignored for that cycle.
- HOLD:
  - hold_req=1 and hold_cnt<HOLD_TIMEOUT → all three holds asserted; hold_cnt increments; stay HOLD.
  - hold_req=1 and hold_cnt==HOLD_TIMEOUT → no holds; next state ERR.
  - hold_req=0 → holds deassert in the same cycle; hold_cnt←0; next state RUN.
  - ex_jump_flag_i is ignored in HOLD because EX is frozen; the jump is taken in RUN after release.
- ERR (exactly one cycle): bus_err_o=1, jump_flag_o=1, jump_addr_o=TRAP_ADDR, flush_if_id_o=flush_id_ex_o=1; hold_cnt←0; next state RUN unconditionally.
- stall_cnt_o increments on each edge where hold_pc_o=1 and holds at 32'hFFFFFFFF.
- Reset asserted mid-HOLD or mid-ERR returns to RUN immediately. No pending bus_err_o or jump survives reset.

Test Plan:
- Load-use: EX load, waddr=5, we=1; ID reads rs1=5, re=1 → one cycle of hold_pc_o=hold_if_id_o=flush_id_ex_o=1. Next cycle (inputs unchanged) all 0. stall_cnt_o=1.
- Zero-register and no-read cases: waddr=0 → no stall. rs2 matches but id_reg2_re_i=0 → no stall.
- Jump priority: ex_jump_flag_i=1, ex_jump_addr_i=32'h123, with bus_hold_i=1 and load_use=1 in the same cycle → jump_flag_o=1, jump_addr_o=32'h123, both flushes=1, no holds, state stays RUN.
- Bus hold: bus_hold_i high for 3 cycles → holds high exactly 3 cycles and drop in the cycle bus_hold_i falls. stall_cnt_o=3.
- Timeout (HOLD_TIMEOUT=16): bus_hold_i held high → holds for 16 cycles. Cycle 17: holds=0. Cycle 18: bus_err_o=1, jump_addr_o=32'h4, flushes=1. Then RUN.
- Async reset: drop rst during HOLD cycle 5 → all outputs 0 immediately, stall_cnt_o=0. After release with bus_hold_i=0 → state RUN, no bus_err_o.
